// File: rtl/cache_l2_ctrl.sv
// cache_l2_ctrl: request-side controller for a direct-mapped L2 with write-through stores,
// read-miss refill from memory and saturating hit/miss counters.
module cache_l2_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_we,
    output logic [DATA_W-1:0] l2_wdata,
    input  logic [DATA_W-1:0] l2_rdata,
    input  logic              l2_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    typedef enum logic [2:0] {IDLE, PROBE, HIT_RD, MEM_RD, MEM_WAIT, FILL, MEM_WR, RESP} state_t;
    state_t state, nxt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata, fill;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_we;
    logic [DATA_W-1:0] cur_wdata;
    logic              mem_nxt;
    // outputs are registered from the next state, so the request being accepted must bypass the latches
    assign cur_addr  = state == IDLE ? req_addr : lat_addr;
    assign cur_we    = state == IDLE ? req_we : lat_we;
    assign cur_wdata = state == IDLE ? req_wdata : lat_wdata;
    assign mem_nxt   = nxt == MEM_RD || nxt == MEM_WR;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = (req_valid && req_ready) ? PROBE : IDLE;
            PROBE:    nxt = lat_we ? MEM_WR : l2_hit ? HIT_RD : MEM_RD;
            HIT_RD:   nxt = RESP;
            MEM_RD:   nxt = mem_req_ready ? MEM_WAIT : MEM_RD;
            MEM_WAIT: nxt = mem_resp_valid ? FILL : MEM_WAIT;
            FILL:     nxt = RESP;
            MEM_WR:   nxt = mem_req_ready ? RESP : MEM_WR;
            RESP:     nxt = resp_ready ? IDLE : RESP;
            default:  nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lat_addr      <= '0;
            lat_we        <= 1'b0;
            lat_wdata     <= '0;
            fill          <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            l2_addr       <= '0;
            l2_we         <= 1'b0;
            l2_wdata      <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_we    <= 1'b0;
            mem_req_wdata <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            state <= nxt;
            if (req_valid && req_ready) begin
                lat_addr  <= req_addr;
                lat_we    <= req_we;
                lat_wdata <= req_wdata;
            end
            req_ready     <= nxt == IDLE;
            resp_valid    <= nxt == RESP;
            l2_addr       <= nxt == IDLE ? '0 : cur_addr;
            l2_we         <= (nxt == PROBE && cur_we) || nxt == FILL;
            l2_wdata      <= (nxt == PROBE && cur_we) ? cur_wdata : nxt == FILL ? mem_resp_data : '0;
            mem_req_valid <= mem_nxt;
            mem_req_addr  <= mem_nxt ? lat_addr : '0;
            mem_req_we    <= nxt == MEM_WR;
            mem_req_wdata <= nxt == MEM_WR ? lat_wdata : '0;
            if (state == MEM_WAIT && mem_resp_valid)
                fill <= mem_resp_data;
            if (state == HIT_RD)
                resp_data <= l2_rdata;
            else if (state == FILL)
                resp_data <= fill;
            else if (state == MEM_WR && mem_req_ready)
                resp_data <= lat_wdata;
            if (state == PROBE && !lat_we && l2_hit && hit_count != '1)
                hit_count <= hit_count + CNT_W'(1);
            if (state == PROBE && !lat_we && !l2_hit && miss_count != '1)
                miss_count <= miss_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_cache_l2_ctrl.sv
// tb_cache_l2_ctrl: randomized bench with L2/memory environment models and a line-level cache reference.
module tb_cache_l2_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        req_ready, resp_valid, l2_we, mem_req_valid, mem_req_we, l2_hit;
    logic [63:0] resp_data, l2_addr, l2_wdata, l2_rdata, mem_req_addr, mem_req_wdata;
    logic [31:0] hit_count, miss_count;
    logic        s_req_ready, s_resp_valid, s_l2_we, s_mem_req_valid, s_mem_req_we;
    logic [63:0] s_resp_data, s_l2_addr, s_l2_wdata, s_mem_req_addr, s_mem_req_wdata;
    logic [1:0]  s_hit_count, s_miss_count;
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    cache_l2_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .l2_addr(l2_addr), .l2_we(l2_we), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata),
        .l2_hit(l2_hit), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(hit_count), .miss_count(miss_count));

    // narrow-counter twin fed the same stimulus, used only to observe saturation
    cache_l2_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .resp_valid(s_resp_valid), .resp_ready(resp_ready),
        .resp_data(s_resp_data), .l2_addr(s_l2_addr), .l2_we(s_l2_we), .l2_wdata(s_l2_wdata), .l2_rdata(l2_rdata),
        .l2_hit(l2_hit), .mem_req_valid(s_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(s_mem_req_addr), .mem_req_we(s_mem_req_we), .mem_req_wdata(s_mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(s_hit_count), .miss_count(s_miss_count));

    // L2 storage: combinational hit, registered read data
    logic [1023:0] l2_v = '0;
    logic [47:0]   l2_t [1024];
    logic [63:0]   l2_d [1024];
    wire  [9:0]    li = l2_addr[15:6];
    assign l2_hit = l2_v[li] && l2_t[li] == l2_addr[63:16];
    always @(posedge clk) begin
        l2_rdata <= l2_d[li];
        if (l2_we) begin
            l2_v[li] <= 1'b1;
            l2_t[li] <= l2_addr[63:16];
            l2_d[li] <= l2_wdata;
        end
    end

    logic [63:0] mem   [logic [63:0]];
    logic [63:0] r_mem [logic [63:0]];
    bit          r_val [1024];
    logic [47:0] r_tag [1024];
    int unsigned r_hit = 0, r_miss = 0;

    function automatic logic [63:0] mdef(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [63:0] a, input logic w, input logic [63:0] wd,
                          input int ms, input int ml, input int rs);
        logic [9:0]  idx = a[15:6];
        logic [63:0] exp_data, saved;
        int exp_lat, exp_l2w, cyc, lat, l2w, g, lc, mstall, rstall;
        bit hit, pend, acc, rdone, done;
        if (w) begin
            exp_data = wd;
            r_mem[a] = wd;
            r_val[idx] = 1'b1;
            r_tag[idx] = a[63:16];
            exp_lat = 3 + ms;
            exp_l2w = 1;
        end else begin
            hit = r_val[idx] && r_tag[idx] == a[63:16];
            exp_data = r_mem.exists(a) ? r_mem[a] : mdef(a);
            if (hit) begin
                r_hit++;
                exp_lat = 3;
                exp_l2w = 0;
            end else begin
                r_miss++;
                r_val[idx] = 1'b1;
                r_tag[idx] = a[63:16];
                exp_lat = 5 + ms + ml;
                exp_l2w = 1;
            end
        end
        g = 0;
        while (!req_ready && g < 50) begin
            tick();
            g++;
        end
        chk("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_addr = a; req_we = w; req_wdata = wd;
        tick();
        req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_we = $urandom_range(0, 1); req_wdata = {$urandom, $urandom};
        cyc = 1; lat = -1; l2w = 0; pend = 0; lc = 0; acc = 0; done = 0; rdone = 0;
        mstall = ms; rstall = rs; saved = '0;
        while (!done && cyc < 300) begin
            if (acc) begin
                if (w) mem[a] = saved;
                else begin pend = 1; lc = ml; end
            end
            mem_resp_valid = 1'b0;
            if (pend) begin
                if (lc == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data = mem.exists(a) ? mem[a] : mdef(a);
                    pend = 0;
                end else lc--;
            end else begin
                mem_resp_valid = $urandom_range(0, 3) == 0;
                mem_resp_data = {$urandom, $urandom};
            end
            if (l2_we) begin
                l2w++;
                chk("l2_we_cycle", 64'(cyc), 64'(w ? 1 : exp_lat - 1));
                chk("l2_wdata", l2_wdata, exp_data);
                chk("l2_addr", l2_addr, a);
            end
            if (mem_req_valid) begin
                chk("mem_req_addr", mem_req_addr, a);
                chk("mem_req_we", 64'(mem_req_we), 64'(w));
                if (w) chk("mem_req_wdata", mem_req_wdata, wd);
                saved = mem_req_wdata;
                if (mstall == 0) mem_req_ready = 1'b1;
                else begin mstall--; mem_req_ready = 1'b0; end
            end else mem_req_ready = 1'b0;
            acc = mem_req_valid && mem_req_ready;
            if (resp_valid) begin
                if (lat < 0) begin
                    lat = cyc;
                    chk("resp_latency", 64'(lat), 64'(exp_lat));
                end
                chk("resp_data", resp_data, exp_data);
                chk("req_ready_busy", 64'(req_ready), 64'(0));
                if (rstall == 0) resp_ready = 1'b1;
                else begin rstall--; resp_ready = 1'b0; end
            end else resp_ready = 1'b0;
            rdone = resp_valid && resp_ready;
            tick();
            cyc++;
            if (rdone) done = 1;
        end
        resp_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        chk("resp_done", 64'(done), 64'(1));
        chk("req_ready_after", 64'(req_ready), 64'(1));
        chk("l2_we_count", 64'(l2w), 64'(exp_l2w));
        chk("hit_count", 64'(hit_count), 64'(r_hit));
        chk("miss_count", 64'(miss_count), 64'(r_miss));
        chk("sat_hit_count", 64'(s_hit_count), 64'(r_hit > 3 ? 3 : r_hit));
        chk("sat_miss_count", 64'(s_miss_count), 64'(r_miss > 3 ? 3 : r_miss));
    endtask

    initial begin
        int cnt;
        logic [63:0] a;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_l2_we", 64'(l2_we), 64'(0));
        chk("rst_l2_addr", l2_addr, 64'h0);
        chk("rst_resp_data", resp_data, 64'h0);
        chk("rst_counts", {hit_count, miss_count}, 64'h0);
        rst_n = 1'b1;
        tick();
        // reset landing in MEM_WAIT with a late memory response
        req_valid = 1'b1; req_addr = 64'h00F0_0000; req_we = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_mem_req_valid", 64'(mem_req_valid), 64'(1));
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("mid_miss_count", 64'(miss_count), 64'(1));
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("arst_resp_valid", 64'(resp_valid), 64'(0));
        chk("arst_req_ready", 64'(req_ready), 64'(1));
        chk("arst_counts", {hit_count, miss_count}, 64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_req_ready", 64'(req_ready), 64'(1));
        chk("rel_mem_req_valid", 64'(mem_req_valid), 64'(0));
        mem_resp_valid = 1'b1; mem_resp_data = 64'hBAD0_BAD0_BAD0_BAD0;
        cnt = 0;
        repeat (3) begin
            tick();
            mem_resp_valid = 1'b0;
            if (l2_we) cnt++;
        end
        chk("late_resp_no_l2_we", 64'(cnt), 64'(0));
        // directed scenarios
        mem[64'h1_2340] = 64'hDEAD_BEEF_0000_0001;
        r_mem[64'h1_2340] = 64'hDEAD_BEEF_0000_0001;
        do_req(64'h1_2340, 1'b0, 64'h0, 0, 4, 0);
        do_req(64'h1_2340, 1'b0, 64'h0, 0, 0, 0);
        do_req(64'h40, 1'b1, 64'h1122_3344_5566_7788, 3, 0, 0);
        do_req(64'h1_0040, 1'b0, 64'h0, 0, 0, 0);
        do_req(64'h40, 1'b0, 64'h0, 1, 2, 0);
        do_req(64'h1_2340, 1'b0, 64'h0, 0, 0, 5);
        repeat (4) do_req(64'h1_2340, 1'b0, 64'h0, 0, 0, 0);
        // randomized traffic over a few indices and tags to mix hits, misses and conflicts
        repeat (150) begin
            a = '0;
            a[17:16] = 2'($urandom_range(0, 3));
            a[8:6] = 3'($urandom_range(0, 7));
            do_req(a, $urandom_range(0, 2) == 0, {$urandom, $urandom},
                   $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cache_l2_ctrl.md
# cache_l2_ctrl

Request-side controller for the direct-mapped L2 (1024 entries, index = addr[15:6], tag = addr[63:16], one 64-bit word per entry, combinational hit, registered read data).
- Accepts one load/store at a time from the L1/core side, probes the L2, and serves read hits from it.
- On a read miss, fetches the word from memory and refills the L2 entry.
- Stores are write-allocate into the L2 and write-through to memory.
- Counts hits and misses.

## Interface
Parameters:
- ADDR_W, 64, address width (fixed geometry requires 64)
- DATA_W, 64, data word width
- CNT_W, 32, width of hit/miss counters

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  upstream request valid
- req_ready  out  1  controller can accept request
- req_addr  in  ADDR_W  request address
- req_we  in  1  1 = store, 0 = load
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  response valid
- resp_ready  in  1  upstream accepts response
- resp_data  out  DATA_W  load data, or store data echoed for stores
- l2_addr  out  ADDR_W  address to L2
- l2_we  out  1  L2 write strobe
- l2_wdata  out  DATA_W  L2 write data
- l2_rdata  in  DATA_W  L2 read data, registered by L2 (valid the cycle after l2_addr is presented)
- l2_hit  in  1  L2 hit, combinational on l2_addr
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  memory address
- mem_req_we  out  1  memory write
- mem_req_wdata  out  DATA_W  memory write data
- mem_resp_valid  in  1  memory read data valid (reads only)
- mem_resp_data  in  DATA_W  memory read data
- hit_count  out  CNT_W  saturating count of load hits
- miss_count  out  CNT_W  saturating count of load misses

## Operation
Request latching:
- Request fields are latched on req_valid && req_ready.
- l2_addr and mem_req_addr always come from the latched address.
- l2_addr is 0 in IDLE.

States:
- IDLE: req_ready=1. On handshake, latch the request and go to PROBE.
- PROBE (one cycle):
  - Store: l2_we=1, l2_wdata=latched wdata (allocates/overwrites regardless of l2_hit); go to MEM_WR.
  - Load with l2_hit=1: hit_count++; go to HIT_RD.
  - Load with l2_hit=0: miss_count++; go to MEM_RD.
- HIT_RD (one cycle): capture l2_rdata into resp_data; go to RESP.
- MEM_RD: mem_req_valid=1, mem_req_we=0. On mem_req_ready, go to MEM_WAIT.
- MEM_WAIT: on mem_resp_valid, capture mem_resp_data into a fill register and go to FILL.
- FILL (one cycle): l2_we=1, l2_wdata=fill register, resp_data=fill register; go to RESP.
- MEM_WR: mem_req_valid=1, mem_req_we=1, mem_req_wdata=latched wdata. On mem_req_ready, set resp_data=latched wdata and go to RESP.
- RESP: resp_valid=1, held with resp_data stable until resp_ready; then go to IDLE.

Rules:
- mem_req_* fields are stable while mem_req_valid=1 and ready=0.
- mem_resp_valid outside MEM_WAIT is ignored.
- Counters increment by 1 and saturate at 2^CNT_W-1; no wrap. Stores never count.
- l2_we is high only in PROBE (stores) and FILL.

## Timing
- Reset (async assert, sync release): state=IDLE. req_ready=1. All other outputs 0, including counters, resp_data and the fill register.
- Reset mid-operation:
  - mem_req_valid and resp_valid drop immediately.
  - In-flight request is discarded; no L2 write occurs.
  - A late mem_resp_valid after reset is ignored.
- Load hit: handshake at edge T; resp_valid high from cycle T+3 (PROBE, HIT_RD, RESP).
- Load miss, memory ready and response both in the first cycle offered: resp_valid at T+5 (PROBE, MEM_RD, MEM_WAIT, FILL, RESP).
- Store, mem_req_ready=1: resp_valid at T+3.
- Back-to-back: req_ready returns to 1 in the cycle after the resp handshake edge. No overlap of requests.

## Test plan
- Reset: hold rst_n=0 mid-MEM_WAIT, then release -> state IDLE, req_ready=1, mem_req_valid=0, counters 0. A mem_resp_valid pulse after reset causes no l2_we.
- Load miss then hit: load 0x0000_0000_0001_2340, memory returns 0xDEAD_BEEF_0000_0001 after 4 cycles -> one FILL cycle with l2_we=1, resp_data=0xDEAD_BEEF_0000_0001, miss_count=1. Repeat the load with the L2 model -> resp at T+3 with same data, hit_count=1.
- Store: store 0x1122_3344_5566_7788 to 0x40 with mem_req_ready low 3 cycles -> l2_we in PROBE only, mem_req fields stable until accepted, resp_data=0x1122_3344_5566_7788, counters unchanged.
- Conflict miss: load 0x1_0040 after 0x40 resident (same index 1, different tag) -> l2_hit=0, memory read issued, entry refilled.
- Backpressure: resp_ready low 5 cycles -> resp_valid and resp_data held, req_ready=0 throughout.
- Saturation: CNT_W=2, 5 load hits -> hit_count stops at 3.
